// File: rtl/fourbit_search.sv
// fourbit_search
//   Binary search over the 4-bit range 0..15 driven by an external comparator.
//   Each PROBE cycle presents a candidate on probe and samples the comparator
//   result (cmp_eq / cmp_lt / cmp_gt) on the next rising edge.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   start        request a new search (only honoured in IDLE)
//   cmp_eq/lt/gt comparator feedback: probe ==, <, > hidden target
//   probe        candidate value, held outside PROBE
//   probe_valid  high while cmp_* is being sampled
//   busy         high from start acceptance through the done cycle
//   done         one-cycle pulse at search end
//   err          search failed (qualified by done)
//   result       last successfully found value
//   probes       probes issued in the last/current search
module fourbit_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    input  logic       cmp_gt,
    output logic [3:0] probe,
    output logic       probe_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] result,
    output logic [2:0] probes
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_FINISH
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_lo, r_hi, r_probe, r_result;
    logic [3:0] w_lo_nxt, w_hi_nxt, w_probe_nxt, w_result_nxt;
    logic [2:0] r_probes, w_probes_nxt;
    logic       r_err, w_err_nxt;
    logic [4:0] w_sum;
    logic       w_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '1;
            r_probe  <= '0;
            r_result <= '0;
            r_probes <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_probe  <= w_probe_nxt;
            r_result <= w_result_nxt;
            r_probes <= w_probes_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_probe_nxt  = r_probe;
        w_result_nxt = r_result;
        w_probes_nxt = r_probes;
        w_err_nxt    = r_err;

        case ({cmp_eq, cmp_lt, cmp_gt})
            3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
            default:                w_onehot = 1'b0;
        endcase

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lo_nxt     = '0;
                    w_hi_nxt     = '1;
                    w_probes_nxt = '0;
                    w_state_nxt  = S_PROBE;
                end
            end
            S_PROBE: begin
                w_probes_nxt = r_probes + 3'd1;
                if (!w_onehot) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (cmp_eq) begin
                    w_result_nxt = r_probe;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_FINISH;
                end else if (cmp_lt) begin
                    // Target above probe: an exhausted upper bound means
                    // the feedback contradicts earlier answers.
                    if (r_probe == r_hi) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_lo_nxt = r_probe + 4'd1;
                    end
                end else begin
                    if (r_probe == r_lo) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_hi_nxt = r_probe - 4'd1;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Midpoint is computed from the next bounds so that probe is already
        // registered and stable during every PROBE cycle.
        w_sum = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
        if (w_state_nxt == S_PROBE) begin
            w_probe_nxt = w_sum[4:1];
        end
    end

    assign probe       = r_probe;
    assign probe_valid = (r_state == S_PROBE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FINISH);
    assign err         = (r_state == S_FINISH) && r_err;
    assign result      = r_result;
    assign probes      = r_probes;

endmodule
